pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage of the MIPS pipeline.
- Sits directly downstream of the branch-decision logic: consumes its PCSrc output together with jump, hazard and debug controls.
- Selects and registers the next PC, generates the IF/ID flush, and runs the fetch state machine (idle / continuous / single-step / halted) used by the debug unit.

Parameters:
NBITS, 32, PC and address width
RESET_PC, 0, PC value loaded at reset

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_PCSrc  input  1  branch taken (BEQ/BNE decision)
i_BranchAddr  input  NBITS  branch target
i_Jump  input  1  J/JAL in ID
i_JumpAddr  input  NBITS  jump target
i_JR  input  1  JR/JALR in ID
i_JRAddr  input  NBITS  register jump target
i_Stall  input  1  hazard-unit stall, hold PC
i_Halt  input  1  HALT opcode fetched
i_DebugRun  input  1  level: continuous execution
i_DebugStep  input  1  one-cycle pulse: execute one cycle
o_PC  output  NBITS  current PC to instruction memory
o_PCPlus4  output  NBITS  o_PC+4, combinational
o_Flush  output  1  flush IF/ID, combinational
o_Halted  output  1  state == HALTED
o_Running  output  1  PC advances this cycle
o_CycleCount  output  32  executed-cycle counter
o_Misaligned  output  1  see optional feature

Behaviour:
- Reset (async, i_rst_n=0): o_PC=RESET_PC, state=IDLE, o_CycleCount=0, o_Misaligned=0. Consequently o_Flush=0, o_Halted=0, o_Running=0.
- Reset asserted mid-operation aborts immediately; no pending step or redirect survives it.
- States and transitions:
  - IDLE: i_DebugRun=1 -> RUN; else i_DebugStep=1 -> STEP.
  - RUN: i_Halt=1 -> HALTED; else i_DebugRun=0 -> IDLE.
  - STEP: i_Halt=1 -> HALTED; else -> IDLE. STEP always lasts exactly one cycle.
  - HALTED: sticky, left only by reset.
  - i_DebugRun and i_DebugStep both high in IDLE -> RUN.
- Advance: o_Running = (state==RUN or STEP) and i_Halt=0. PC updates only when o_Running=1.
- Next-PC priority, first match wins:
  1. i_PCSrc -> i_BranchAddr. Applies even when i_Stall=1: an older instruction's redirect beats a younger-instruction stall.
  2. i_Stall -> hold PC.
  3. i_JR -> i_JRAddr.
  4. i_Jump -> i_JumpAddr.
  5. Otherwise -> o_PC+4.
- Target alignment: bits [1:0] of every selected target forced to 0.
- Arithmetic: PC+4 wraps modulo 2^NBITS (0xFFFFFFFC -> 0x00000000), no flag.
- o_Flush = o_Running and (i_PCSrc, or (!i_Stall and (i_JR or i_Jump))). Asserted in the same cycle as the redirect edge.
- Latency: a new PC is visible on o_PC one cycle after selection.
- o_CycleCount: +1 on every cycle with o_Running=1, including stall cycles. Saturates at 0xFFFFFFFF.
- HALT fetched: PC frozen at the HALT address; no flush generated.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: if a selected redirect target has bits[1:0] != 0 while o_Running=1, then:
  - o_Misaligned is set sticky;
  - the PC is held (not updated);
  - state -> HALTED on that edge;
  - o_Flush is still asserted.
- Undefined: low bits silently cleared; o_Misaligned tied to 0.

Test Plan:
- Reset then i_DebugRun=1 for 4 cycles -> o_PC sequence 0,4,8,12,16; o_CycleCount=4; o_Flush=0 throughout.
- PC=0x20, i_PCSrc=1, i_BranchAddr=0x100, i_Stall=1 same cycle -> o_Flush=1; next o_PC=0x100.
- PC=0x40, i_Jump=1 (target 0x80) with i_Stall=1 for 2 cycles, then i_Stall=0 -> PC holds 0x40 during the stall with o_Flush=0; then o_PC=0x80 with o_Flush=1 on the release cycle.
- IDLE with i_DebugStep pulsed 3 times, gaps of 5 cycles -> o_PC advances 0->4->8->12 only on the steps; o_CycleCount=3.
- i_Halt=1 at PC=0x1C -> o_Halted=1, PC stays 0x1C for 10 cycles regardless of i_DebugRun/i_DebugStep; i_rst_n pulse -> PC=0, IDLE.
- PC=0xFFFFFFFC running -> next o_PC=0x00000000. With PC_ALIGN_CHECK_EN, i_JRAddr=0x102 -> o_Misaligned=1, o_Halted=1, PC unchanged.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter and fetch-control stage of the MIPS pipeline. Selects and registers the
//   next PC, generates the IF/ID flush and runs the debug fetch state machine
//   (idle / continuous / single-step / halted).
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN  - when defined, a redirect to a target with bits[1:0] != 0 sets the
//                        sticky o_Misaligned flag, holds the PC and halts fetch. When undefined,
//                        low target bits are silently cleared and o_Misaligned is tied to 0.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_PCSrc, i_BranchAddr   taken branch and its target (highest priority, beats stall)
//   i_Jump, i_JumpAddr      J/JAL in ID and its target
//   i_JR, i_JRAddr          JR/JALR in ID and its register target
//   i_Stall                 hazard stall, hold PC
//   i_Halt                  HALT opcode fetched
//   i_DebugRun, i_DebugStep debug controls: level run, one-cycle step pulse
//   o_PC, o_PCPlus4         current PC and PC+4 (combinational)
//   o_Flush                 flush IF/ID (combinational, same cycle as redirect edge)
//   o_Halted, o_Running     state is HALTED / PC advances this cycle
//   o_CycleCount            saturating count of cycles with o_Running=1
//   o_Misaligned            sticky misaligned-redirect flag (0 unless PC_ALIGN_CHECK_EN)
// ---------------------------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int unsigned      NBITS    = 32,
    parameter logic [NBITS-1:0] RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_PCSrc,
    input  logic [NBITS-1:0] i_BranchAddr,
    input  logic             i_Jump,
    input  logic [NBITS-1:0] i_JumpAddr,
    input  logic             i_JR,
    input  logic [NBITS-1:0] i_JRAddr,
    input  logic             i_Stall,
    input  logic             i_Halt,
    input  logic             i_DebugRun,
    input  logic             i_DebugStep,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_PCPlus4,
    output logic             o_Flush,
    output logic             o_Halted,
    output logic             o_Running,
    output logic [31:0]      o_CycleCount,
    output logic             o_Misaligned
);

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [31:0]      cycle_q, cycle_d;

    logic             running;
    logic             redirect;
    logic             hold;
    logic [NBITS-1:0] target_raw;
    logic [NBITS-1:0] pc_plus4;
    logic             misaligned_hit;

    assign pc_plus4 = pc_q + NBITS'(4);
    assign running  = ((state_q == StRun) || (state_q == StStep)) && !i_Halt;

    // Next-PC source. A branch resolved for an older instruction beats a stall caused by a
    // younger one, so PCSrc is tested before Stall.
    always_comb begin
        redirect   = 1'b0;
        hold       = 1'b0;
        target_raw = '0;
        if (i_PCSrc) begin
            redirect   = 1'b1;
            target_raw = i_BranchAddr;
        end else if (i_Stall) begin
            hold = 1'b1;
        end else if (i_JR) begin
            redirect   = 1'b1;
            target_raw = i_JRAddr;
        end else if (i_Jump) begin
            redirect   = 1'b1;
            target_raw = i_JumpAddr;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q;

    assign misaligned_hit = running && redirect && (target_raw[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
        end else if (misaligned_hit) begin
            misaligned_q <= 1'b1;
        end
    end

    assign o_Misaligned = misaligned_q;
`else
    logic unused_target_low;

    assign unused_target_low = ^target_raw[1:0];
    assign misaligned_hit    = 1'b0;
    assign o_Misaligned      = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (running && !hold && !misaligned_hit) begin
            pc_d = redirect ? {target_raw[NBITS-1:2], 2'b00} : pc_plus4;
        end
    end

    always_comb begin
        cycle_d = cycle_q;
        if (running && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_DebugRun) begin
                    state_d = StRun;
                end else if (i_DebugStep) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (i_Halt || misaligned_hit) begin
                    state_d = StHalted;
                end else if (!i_DebugRun) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                state_d = (i_Halt || misaligned_hit) ? StHalted : StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cycle_q <= cycle_d;
        end
    end

    assign o_PC         = pc_q;
    assign o_PCPlus4    = pc_plus4;
    assign o_Flush      = running && redirect;
    assign o_Halted     = (state_q == StHalted);
    assign o_Running    = running;
    assign o_CycleCount = cycle_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed self-checking bench for pc_fetch_ctrl with hand-computed expected values.
//   Honours PC_ALIGN_CHECK_EN for the misaligned-target cases.
// ---------------------------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_PCSrc;
    logic [31:0] i_BranchAddr;
    logic        i_Jump;
    logic [31:0] i_JumpAddr;
    logic        i_JR;
    logic [31:0] i_JRAddr;
    logic        i_Stall;
    logic        i_Halt;
    logic        i_DebugRun;
    logic        i_DebugStep;
    logic [31:0] o_PC;
    logic [31:0] o_PCPlus4;
    logic        o_Flush;
    logic        o_Halted;
    logic        o_Running;
    logic [31:0] o_CycleCount;
    logic        o_Misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_ctrl #(
        .NBITS    (32),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_PCSrc      (i_PCSrc),
        .i_BranchAddr (i_BranchAddr),
        .i_Jump       (i_Jump),
        .i_JumpAddr   (i_JumpAddr),
        .i_JR         (i_JR),
        .i_JRAddr     (i_JRAddr),
        .i_Stall      (i_Stall),
        .i_Halt       (i_Halt),
        .i_DebugRun   (i_DebugRun),
        .i_DebugStep  (i_DebugStep),
        .o_PC         (o_PC),
        .o_PCPlus4    (o_PCPlus4),
        .o_Flush      (o_Flush),
        .o_Halted     (o_Halted),
        .o_Running    (o_Running),
        .o_CycleCount (o_CycleCount),
        .o_Misaligned (o_Misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_PCSrc      = 1'b0;
        i_BranchAddr = '0;
        i_Jump       = 1'b0;
        i_JumpAddr   = '0;
        i_JR         = 1'b0;
        i_JRAddr     = '0;
        i_Stall      = 1'b0;
        i_Halt       = 1'b0;
        i_DebugRun   = 1'b0;
        i_DebugStep  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    // Requires state RUN: redirects the PC with a jump.
    task automatic jump_to(input logic [31:0] addr);
        i_Jump     = 1'b1;
        i_JumpAddr = addr;
        tick();
        i_Jump = 1'b0;
    endtask

    initial begin
        clear_inputs();
        i_rst_n = 1'b0;
        #3;
        check("rst_pc", o_PC, 32'h0);
        check("rst_flush", {31'b0, o_Flush}, 32'd0);
        check("rst_halted", {31'b0, o_Halted}, 32'd0);
        check("rst_running", {31'b0, o_Running}, 32'd0);
        check("rst_cycles", o_CycleCount, 32'd0);
        check("rst_misaligned", {31'b0, o_Misaligned}, 32'd0);
        check("rst_pcplus4", o_PCPlus4, 32'h4);
        tick();
        i_rst_n = 1'b1;

        // Continuous run for exactly four advancing cycles.
        i_DebugRun = 1'b1;
        tick();
        check("run_start_pc", o_PC, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("run_flush", {31'b0, o_Flush}, 32'd0);
            check("run_running", {31'b0, o_Running}, 32'd1);
            if (k == 4) i_DebugRun = 1'b0;
            tick();
            check("run_pc", o_PC, 32'(4 * k));
        end
        check("run_cycles", o_CycleCount, 32'd4);
        check("run_back_idle", {31'b0, o_Running}, 32'd0);

        // Branch taken during a stall still redirects.
        do_reset();
        i_DebugRun = 1'b1;
        tick();
        jump_to(32'h20);
        check("pre_branch_pc", o_PC, 32'h20);
        i_PCSrc      = 1'b1;
        i_BranchAddr = 32'h100;
        i_Stall      = 1'b1;
        #1;
        check("branch_stall_flush", {31'b0, o_Flush}, 32'd1);
        tick();
        check("branch_stall_pc", o_PC, 32'h100);
        i_PCSrc = 1'b0;
        i_Stall = 1'b0;

        // JR beats Jump; branch beats JR.
        i_JR       = 1'b1;
        i_JRAddr   = 32'h200;
        i_Jump     = 1'b1;
        i_JumpAddr = 32'h300;
        tick();
        check("jr_over_jump", o_PC, 32'h200);
        i_PCSrc      = 1'b1;
        i_BranchAddr = 32'h400;
        tick();
        check("branch_over_jr", o_PC, 32'h400);
        clear_inputs();
        i_DebugRun = 1'b1;

        // Jump held off by a two-cycle stall.
        jump_to(32'h40);
        i_Jump     = 1'b1;
        i_JumpAddr = 32'h80;
        i_Stall    = 1'b1;
        #1;
        check("stall1_flush", {31'b0, o_Flush}, 32'd0);
        tick();
        check("stall1_pc", o_PC, 32'h40);
        check("stall2_flush", {31'b0, o_Flush}, 32'd0);
        tick();
        check("stall2_pc", o_PC, 32'h40);
        i_Stall = 1'b0;
        #1;
        check("release_flush", {31'b0, o_Flush}, 32'd1);
        tick();
        check("release_pc", o_PC, 32'h80);
        i_Jump = 1'b0;

        // PC+4 wraps.
        jump_to(32'hFFFF_FFFC);
        check("wrap_pre_pc", o_PC, 32'hFFFF_FFFC);
        check("wrap_pcplus4", o_PCPlus4, 32'h0);
        tick();
        check("wrap_pc", o_PC, 32'h0);

        // Misaligned JR target.
        i_JR     = 1'b1;
        i_JRAddr = 32'h102;
        #1;
        check("misalign_flush", {31'b0, o_Flush}, 32'd1);
        tick();
        i_JR = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc", o_PC, 32'h0);
        check("misalign_flag", {31'b0, o_Misaligned}, 32'd1);
        check("misalign_halted", {31'b0, o_Halted}, 32'd1);
`else
        check("misalign_pc", o_PC, 32'h100);
        check("misalign_flag", {31'b0, o_Misaligned}, 32'd0);
        check("misalign_halted", {31'b0, o_Halted}, 32'd0);
`endif

        // Single-step: three pulses, five-cycle gaps.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            i_DebugStep = 1'b1;
            #1;
            check("step_idle_running", {31'b0, o_Running}, 32'd0);
            tick();
            i_DebugStep = 1'b0;
            check("step_running", {31'b0, o_Running}, 32'd1);
            tick();
            check("step_pc", o_PC, 32'(4 * k));
            repeat (5) tick();
            check("step_gap_pc", o_PC, 32'(4 * k));
        end
        check("step_cycles", o_CycleCount, 32'd3);

        // HALT: frozen PC, no flush, sticky until reset.
        do_reset();
        i_DebugRun = 1'b1;
        tick();
        jump_to(32'h1C);
        check("halt_pre_pc", o_PC, 32'h1C);
        i_Halt     = 1'b1;
        i_Jump     = 1'b1;
        i_JumpAddr = 32'h80;
        #1;
        check("halt_flush", {31'b0, o_Flush}, 32'd0);
        check("halt_running", {31'b0, o_Running}, 32'd0);
        tick();
        i_Halt = 1'b0;
        i_Jump = 1'b0;
        check("halted", {31'b0, o_Halted}, 32'd1);
        check("halt_pc", o_PC, 32'h1C);
        for (int k = 0; k < 10; k++) begin
            i_DebugRun  = k[0];
            i_DebugStep = ~k[0];
            tick();
        end
        check("halt_sticky_pc", o_PC, 32'h1C);
        check("halt_sticky", {31'b0, o_Halted}, 32'd1);
        check("halt_sticky_running", {31'b0, o_Running}, 32'd0);
        clear_inputs();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_pc", o_PC, 32'h0);
        check("async_rst_halted", {31'b0, o_Halted}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'b0, o_Running}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
